// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: on-screen pixel reads always win, buffered CPU writes fill idle slots.
// Define VGA_FB_ARB_CLEAR_EN to build in the whole-frame clear engine (DRAIN/CLEAR FSM).
module vga_fb_arbiter #(
    parameter int X0    = 76,
    parameter int Y0    = 100,
    parameter int W     = 488,
    parameter int H     = 280,
    parameter int AW    = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_valid,
    input  logic [10:0]              pix_x,
    input  logic [10:0]              pix_y,
    output logic [11:0]              color_out,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    input  logic [AW-1:0]            cpu_addr,
    input  logic [11:0]              cpu_data,
    input  logic                     clr_start,
    input  logic [11:0]              clr_color,
    output logic                     clr_busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [AW-1:0]            mem_addr,
    output logic                     mem_we,
    output logic [11:0]              mem_wdata,
    input  logic [11:0]              mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int AREA = W * H;
    localparam logic [AW:0]   AREA_X   = (AW+1)'(AREA);
    localparam logic [AW-1:0] LAST_PIX = AW'(AREA - 1);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [11:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [AW-1:0] pix_addr;
    logic [AW-1:0] head_addr;
    logic [11:0]   head_data;
    logic          head_in_range;

    logic          clearing;
    logic          clr_grant;
    logic [AW-1:0] clr_ptr_v;
    logic [11:0]   clr_col_v;

    logic          slot_we;
    logic [AW-1:0] slot_addr;
    logic [11:0]   slot_wdata;
    logic          rd_d1;
    logic          rd_d2;

    // Linear address inside the window; wraps in AW bits, range is the generator's job.
    assign pix_addr = (AW'(pix_y) - AW'(Y0)) * AW'(W) + (AW'(pix_x) - AW'(X0));

    assign full          = (count == FULL_CNT);
    assign empty         = (count == '0);
    assign push          = cpu_valid && cpu_ready;
    assign head_addr     = fifo_addr[rd_ptr];
    assign head_data     = fifo_data[rd_ptr];
    assign head_in_range = ({1'b0, head_addr} < AREA_X);
    assign fifo_level    = count;

`ifdef VGA_FB_ARB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_ptr;
    logic [11:0]   clr_col;

    assign clearing  = (state == CLEAR);
    assign clr_ptr_v = clr_ptr;
    assign clr_col_v = clr_col;
    assign cpu_ready = !full && (state == IDLE);
    assign clr_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_ptr <= '0;
            clr_col <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && clr_start)
                clr_col <= clr_color;
            if (state == DRAIN && empty)
                clr_ptr <= '0;
            else if (clr_grant)
                clr_ptr <= clr_ptr + AW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_start) state_next = DRAIN;
            DRAIN:   if (empty) state_next = CLEAR;
            CLEAR:   if (clr_grant && clr_ptr == LAST_PIX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`else
    logic unused_clr;

    assign clearing   = 1'b0;
    assign clr_ptr_v  = '0;
    assign clr_col_v  = '0;
    assign cpu_ready  = !full;
    assign clr_busy   = 1'b0;
    assign unused_clr = ^{clr_start, clr_color, clr_grant};
`endif

    // One memory slot per cycle: pixel read, then clear write, then FIFO drain.
    always_comb begin
        slot_we    = 1'b0;
        slot_addr  = mem_addr;
        slot_wdata = mem_wdata;
        pop        = 1'b0;
        clr_grant  = 1'b0;
        if (pix_valid) begin
            slot_addr = pix_addr;
        end else if (clearing) begin
            slot_we    = 1'b1;
            slot_addr  = clr_ptr_v;
            slot_wdata = clr_col_v;
            clr_grant  = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
            if (head_in_range) begin
                slot_we    = 1'b1;
                slot_addr  = head_addr;
                slot_wdata = head_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_addr;
            fifo_data[wr_ptr] <= cpu_data;
        end
    end

    // rd_d2 marks that the word now on mem_rdata belongs to an on-screen read.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_d1     <= 1'b0;
            rd_d2     <= 1'b0;
        end else begin
            mem_we    <= slot_we;
            mem_addr  <= slot_addr;
            mem_wdata <= slot_wdata;
            rd_d1     <= pix_valid;
            rd_d2     <= rd_d1;
        end
    end

    assign color_out = rd_d2 ? mem_rdata : 12'h000;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: random traffic against a queue-based slot model.
// With VGA_FB_ARB_CLEAR_EN defined, a small window keeps full clears short.
module tb_vga_fb_arbiter;

`ifdef VGA_FB_ARB_CLEAR_EN
    localparam int TW = 16;
    localparam int TH = 8;
`else
    localparam int TW = 488;
    localparam int TH = 280;
`endif
    localparam int TX0    = 76;
    localparam int TY0    = 100;
    localparam int TAW    = 18;
    localparam int TDEPTH = 4;
    localparam int AREA   = TW * TH;
    localparam int AMASK  = (1 << TAW) - 1;

    logic            clk;
    logic            rst;
    logic            pix_valid;
    logic [10:0]     pix_x;
    logic [10:0]     pix_y;
    logic [11:0]     color_out;
    logic            cpu_valid;
    logic            cpu_ready;
    logic [TAW-1:0]  cpu_addr;
    logic [11:0]     cpu_data;
    logic            clr_start;
    logic [11:0]     clr_color;
    logic            clr_busy;
    logic [$clog2(TDEPTH):0] fifo_level;
    logic [TAW-1:0]  mem_addr;
    logic            mem_we;
    logic [11:0]     mem_wdata;
    logic [11:0]     mem_rdata;

    vga_fb_arbiter #(
        .X0(TX0), .Y0(TY0), .W(TW), .H(TH), .AW(TAW), .DEPTH(TDEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .color_out(color_out),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .fifo_level(fifo_level),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] init_word(input int i);
        if (i == 0) return 12'hABC;
        return 12'((i * 193 + 71) ^ (i >> 3));
    endfunction

    // Frame RAM: synchronous read, contents start from init_word until written.
    logic [11:0] ram     [0:(1<<TAW)-1];
    bit          written [0:(1<<TAW)-1];
    always @(posedge clk) begin
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr));
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    typedef struct {
        int addr;
        int data;
    } entry_t;

    logic [11:0] shadow [0:(1<<TAW)-1];
    entry_t      q[$];
    int          mode;
    int          cptr;
    int          ccol;
    int          e_we;
    int          e_addr;
    int          e_wdata;
    int          e_col1;
    int          e_col2;
    int          n_checks;
    int          n_fail;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mode    = 0;
        cptr    = 0;
        ccol    = 0;
        e_we    = 0;
        e_addr  = 0;
        e_wdata = 0;
        e_col1  = 0;
        e_col2  = 0;
    endtask

    // One memory slot of the reference model, decided from the priority rules.
    task automatic modelStep(input bit pv, input int px, input int py, input bit cv,
                             input int ca, input int cd, input bit cs, input int cc);
        int pre_mode;
        int pre_size;
        bit ready;
        bit last;
        int col;
        entry_t e;
        pre_mode = mode;
        pre_size = q.size();
        ready    = (pre_size < TDEPTH) && (pre_mode == 0);
        last     = 1'b0;
        col      = 0;
        e_we     = 0;
        if (pv) begin
            e_addr = ((py - TY0) * TW + (px - TX0)) & AMASK;
            col    = int'(shadow[e_addr]);
        end else if (pre_mode == 2) begin
            e_we    = 1;
            e_addr  = cptr;
            e_wdata = ccol;
            shadow[cptr] = 12'(ccol);
            last = (cptr == AREA - 1);
            cptr++;
        end else if (pre_size > 0) begin
            e = q.pop_front();
            if (e.addr < AREA) begin
                e_we    = 1;
                e_addr  = e.addr;
                e_wdata = e.data;
                shadow[e.addr] = 12'(e.data);
            end
        end
        if (cv && ready) begin
            e.addr = ca;
            e.data = cd;
            q.push_back(e);
        end
        e_col2 = e_col1;
        e_col1 = col;
`ifdef VGA_FB_ARB_CLEAR_EN
        if (pre_mode == 0 && cs) begin
            mode = 1;
            ccol = cc;
        end else if (pre_mode == 1 && pre_size == 0) begin
            mode = 2;
            cptr = 0;
        end else if (pre_mode == 2 && last) begin
            mode = 0;
        end
`endif
    endtask

    task automatic checkAll();
        checkOutput("mem_we",     int'(mem_we),     e_we);
        checkOutput("mem_addr",   int'(mem_addr),   e_addr);
        checkOutput("mem_wdata",  int'(mem_wdata),  e_wdata);
        checkOutput("color_out",  int'(color_out),  e_col2);
        checkOutput("cpu_ready",  int'(cpu_ready),  int'((q.size() < TDEPTH) && (mode == 0)));
        checkOutput("fifo_level", int'(fifo_level), q.size());
        checkOutput("clr_busy",   int'(clr_busy),   int'(mode != 0));
    endtask

    // Check the previous cycle's outcome, then drive and model the next cycle.
    task automatic applyStimulus(input bit r, input bit pv, input int px, input int py,
                                 input bit cv, input int ca, input int cd,
                                 input bit cs, input int cc);
        @(negedge clk);
        checkAll();
        rst       = r;
        pix_valid = pv;
        pix_x     = 11'(px);
        pix_y     = 11'(py);
        cpu_valid = cv;
        cpu_addr  = TAW'(ca);
        cpu_data  = 12'(cd);
        clr_start = cs;
        clr_color = 12'(cc);
        if (r) modelReset();
        else modelStep(pv, px, py, cv, ca, cd, cs, cc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pixelRead(input int px, input int py);
        applyStimulus(0, 1, px, py, 0, 0, 0, 0, 0);
    endtask

    task automatic randPixelWithWrite(input int ca, input int cd);
        applyStimulus(0, 1, TX0 + $urandom_range(0, TW - 1), TY0 + $urandom_range(0, TH - 1),
                      1, ca, cd, 0, 0);
    endtask

    int pv_state;
    int wa;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < (1 << TAW); i++) shadow[i] = init_word(i);
        rst = 1'b1; pix_valid = 0; pix_x = 0; pix_y = 0; cpu_valid = 0;
        cpu_addr = 0; cpu_data = 0; clr_start = 0; clr_color = 0;
        @(posedge clk);
        modelReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        pixelRead(TX0, TY0);
        pixelRead(TX0 + TW - 1, TY0 + TH - 1);
        idle(3);

        applyStimulus(0, 0, 0, 0, 1, 5, 12'h123, 0, 0);
        idle(3);
        pixelRead(TX0 + 5, TY0);
        idle(3);

        for (int i = 0; i < 6; i++) randPixelWithWrite(10 + i, 12'h200 + i);
        for (int i = 0; i < 3; i++) randPixelWithWrite(30, 12'h555);
        idle(6);

        applyStimulus(0, 0, 0, 0, 1, AREA, 12'h777, 0, 0);
        idle(3);

`ifdef VGA_FB_ARB_CLEAR_EN
        randPixelWithWrite(40, 12'h0AA);
        randPixelWithWrite(41, 12'h0BB);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'hF00);
        for (int i = 0; i < AREA + 60; i++) begin
            if (i == AREA / 2)
                applyStimulus(0, 0, 0, 0, 1, 3, 12'h0F0, 1, 12'h00F);
            else if (i % 7 == 3)
                pixelRead(TX0 + (i % TW), TY0 + (i % TH));
            else
                applyStimulus(0, 0, 0, 0, 1, 3, 12'h0F0, 0, 0);
        end
        for (int i = 0; i < 3; i++) pixelRead(TX0 + i, TY0 + i);
        idle(2);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h0C0);
        idle(20);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
`endif

        pv_state = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) pv_state = 1 - pv_state;
            wa = ($urandom_range(0, 9) == 0) ? AREA + $urandom_range(0, 15)
                                              : $urandom_range(0, AREA - 1);
            applyStimulus(0, pv_state[0],
                          TX0 + $urandom_range(0, TW - 1), TY0 + $urandom_range(0, TH - 1),
                          $urandom_range(0, 1) == 1, wa, $urandom_range(0, 4095),
                          $urandom_range(0, 499) == 0, $urandom_range(0, 4095));
        end
        idle(4);
        for (int i = 0; i < 40; i++) pixelRead(TX0 + $urandom_range(0, TW - 1), TY0 + $urandom_range(0, TH - 1));
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Frame-buffer access controller between the VGA timing generator and a single-port 12-bit frame memory. It serves on-screen pixel reads with absolute priority. CPU pixel writes are buffered in a small FIFO and drained into idle memory cycles. A built-in clear engine can fill the whole frame with one colour. The block sits between the CPU store path, the frame RAM, and the `color_in` input of the VGA timing generator.

## Interface
- `X0`, 76: window left edge (absolute x).
- `Y0`, 100: window top edge (absolute y).
- `W`, 488: window width in pixels.
- `H`, 280: window height in lines.
- `AW`, 18: memory address width; must satisfy W*H ≤ 2^AW.
- `DEPTH`, 4: write FIFO depth (power of two, ≥2).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `pix_valid`  in  1  requested pixel lies inside the window.
- `pix_x`  in  11  absolute x of the requested pixel.
- `pix_y`  in  11  absolute y of the requested pixel.
- `color_out`  out  12  pixel colour to the timing generator.
- `cpu_valid`  in  1  write request.
- `cpu_ready`  out  1  FIFO can accept the request.
- `cpu_addr`  in  AW  linear pixel address.
- `cpu_data`  in  12  pixel colour.
- `clr_start`  in  1  start a frame clear (single-cycle pulse).
- `clr_color`  in  12  fill colour; sampled together with `clr_start`.
- `clr_busy`  out  1  clear sequence in progress.
- `fifo_level`  out  $clog2(DEPTH)+1  current number of FIFO entries.
- `mem_addr`  out  AW  memory address (registered).
- `mem_we`  out  1  memory write enable (registered).
- `mem_wdata`  out  12  memory write data (registered).
- `mem_rdata`  in  12  memory read data; valid 1 cycle after the address.

## Operation
- Pixel address: (pix_y−Y0)*W + (pix_x−X0), computed in AW bits. Range is checked only via `pix_valid`.
- Per-cycle slot priority:
  1. `pix_valid`: read at the pixel address.
  2. State CLEAR: write `clr_color` at `clr_ptr`.
  3. FIFO non-empty: pop one entry and write it. If the entry's `cpu_addr` ≥ W*H, it is popped and discarded with `mem_we`=0.
  4. Otherwise: `mem_we`=0 and `mem_addr` holds its value.
- FIFO push happens when `cpu_valid && cpu_ready`. Same-cycle push and pop are allowed; the level is then unchanged.
- `cpu_ready` = !full && state==IDLE.
- Clear FSM:
  - IDLE: on `clr_start`, latch `clr_color` → DRAIN. `clr_start` is ignored in all other states.
  - DRAIN: FIFO drains normally, no pushes accepted. When the FIFO is empty, `clr_ptr`←0 → CLEAR.
  - CLEAR: `clr_ptr` increments only on a granted write slot. The write at W*H−1 → IDLE.
- `clr_busy` = state≠IDLE.
- `color_out` = `mem_rdata` when the slot two cycles earlier was a pixel read, else 12'h000.
- Reset values:
  - All outputs 0, except `cpu_ready`=1 from the first cycle after reset.
  - FIFO empty, state IDLE.
  - Reset mid-clear aborts the clear. Queued writes are lost.

## Timing
- Pixel latency: `pix_valid` at cycle t → `mem_addr` at t+1 → `color_out` valid during t+2. The timing generator issues coordinates 2 cycles ahead.
- CPU write: accepted at cycle t. With the FIFO empty and `pix_valid` low at t+1, `mem_we` is asserted during t+2.
- During a continuous active window, writes stall. The FIFO fills and `cpu_ready` falls after DEPTH accepts. Draining resumes on the first cycle with `pix_valid` low.
- A full clear takes W*H free slots; in practice it spans several frames. `clr_busy` falls the cycle after the final write is issued.
- FIFO pointers wrap modulo DEPTH. `fifo_level` saturates at DEPTH; no overflow is possible.

## Configuration
- `VGA_FB_ARB_CLEAR_EN` defined: DRAIN/CLEAR states and `clr_ptr` are compiled in, as described above.
- Not defined:
  - FSM is removed; `clr_start` and `clr_color` are ignored.
  - `clr_busy` is tied 0.
  - `cpu_ready` = !full.
  - The slot priority is pixel, then FIFO.

## Test plan
- Pixel read: `pix_valid` with (76,100), memory word 0 = 12'hABC → `mem_addr`=0 at t+1, `color_out`=12'hABC at t+2. (563,379) → `mem_addr`=136639.
- Write during blanking: push addr 5, data 12'h123 with `pix_valid`=0 → `mem_we`=1, `mem_addr`=5, `mem_wdata`=12'h123 two cycles after accept.
- Stall: hold `pix_valid`=1 and offer 6 writes → 4 accepted, then `cpu_ready`=0, `fifo_level`=4, no `mem_we`. Drop `pix_valid` → 4 writes in order on consecutive cycles.
- Out-of-range write: push addr 136640 → popped, `mem_we` stays 0, `fifo_level` returns to 0.
- Clear (macro on): 2 writes queued, pulse `clr_start` with 12'hF00 → the 2 writes are issued first, then 136640 writes of 12'hF00. `cpu_ready`=0 throughout; `clr_busy` falls after the last write. A second `clr_start` mid-clear has no effect.
- Reset mid-clear: assert `rst` → next cycle `clr_busy`=0, `mem_we`=0, `fifo_level`=0, `cpu_ready`=1.
